tone_player: RTL and testbench



---
 rtl/tone_player.sv | 138 +++++++++++++
 tb/tb_tone_player.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_player.sv
// Timed square-wave tone generator: plays one (freq Hz, dur ms) note per start strobe
// using an accumulate-and-wrap phase counter, then pulses done.
module tone_player #(
  parameter int unsigned CLK_HZ = 48_000_000,
  parameter int unsigned FREQ_W = 10,
  parameter int unsigned DUR_W  = 10
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [FREQ_W-1:0] freq,
  input  logic [DUR_W-1:0]  dur,
  input  logic              start,
  input  logic              stop,
  output logic              tone,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MS_CYCLES = CLK_HZ / 1000;
  localparam int unsigned ACC_W     = $clog2(CLK_HZ) + 1;
  localparam int unsigned MS_W      = $clog2(MS_CYCLES);
  localparam logic [ACC_W-1:0] CLK_MOD = ACC_W'(CLK_HZ);
  localparam logic [MS_W-1:0]  MS_LAST = MS_W'(MS_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [FREQ_W-1:0] r_f_q;
  logic [DUR_W-1:0]  r_dur_left;
  logic [MS_W-1:0]   r_ms_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_tone;
  logic              r_busy;
  logic              r_done;

  logic [FREQ_W-1:0] w_f_q_nxt;
  logic [DUR_W-1:0]  w_dur_nxt;
  logic [MS_W-1:0]   w_ms_nxt;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_tone_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  logic [ACC_W-1:0]  w_sum;
  logic              w_wrap;
  logic              w_ms_wrap;
  logic              w_last;
  logic              w_accept;

  // Phase step is 2*f so each wrap is a half period of the output.
  assign w_sum     = r_acc + ACC_W'({r_f_q, 1'b0});
  assign w_wrap    = (w_sum >= CLK_MOD);
  assign w_ms_wrap = (r_ms_cnt == MS_LAST);
  assign w_last    = w_ms_wrap && (r_dur_left == DUR_W'(1));
  assign w_accept  = start && !stop;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && (dur != '0)) w_state_nxt = S_PLAY;
      S_PLAY: if (stop || w_last)          w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output next values; stop or the final cycle force tone low
  always_comb begin
    w_f_q_nxt  = r_f_q;
    w_dur_nxt  = r_dur_left;
    w_ms_nxt   = r_ms_cnt;
    w_acc_nxt  = r_acc;
    w_tone_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_busy_nxt = (w_state_nxt == S_PLAY);
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_f_q_nxt  = freq;
          w_dur_nxt  = dur;
          w_ms_nxt   = '0;
          w_acc_nxt  = '0;
          w_done_nxt = (dur == '0);
        end
      end
      S_PLAY: begin
        if (!stop && !w_last) begin
          w_acc_nxt  = w_wrap ? (w_sum - CLK_MOD) : w_sum;
          w_ms_nxt   = w_ms_wrap ? '0 : (r_ms_cnt + MS_W'(1));
          w_dur_nxt  = w_ms_wrap ? (r_dur_left - DUR_W'(1)) : r_dur_left;
          w_tone_nxt = r_tone ^ w_wrap;
        end else if (!stop) begin
          w_done_nxt = 1'b1;
        end
      end
      default: w_done_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_f_q      <= '0;
      r_dur_left <= '0;
      r_ms_cnt   <= '0;
      r_acc      <= '0;
      r_tone     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_f_q      <= w_f_q_nxt;
      r_dur_left <= w_dur_nxt;
      r_ms_cnt   <= w_ms_nxt;
      r_acc      <= w_acc_nxt;
      r_tone     <= w_tone_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign tone = r_tone;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player; expected tone is the closed-form toggle count
// floor(i*2*f/CLK_HZ) mod 2 at PLAY cycle i.
module tb_tone_player;

  localparam int unsigned CLK_HZ    = 20000;
  localparam int unsigned MS_CYCLES = CLK_HZ / 1000;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic [9:0] freq = '0;
  logic [9:0] dur = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       tone;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  tone_player #(.CLK_HZ(CLK_HZ), .FREQ_W(10), .DUR_W(10)) dut (
    .clk   (clk),
    .nreset(nreset),
    .freq  (freq),
    .dur   (dur),
    .start (start),
    .stop  (stop),
    .tone  (tone),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_tone(input int unsigned idx, input int unsigned f);
    longint unsigned a;
    longint unsigned b;
    longint unsigned toggles;
    a = idx;
    b = f;
    toggles = (a * 2 * b) / CLK_HZ;
    return toggles[0];
  endfunction

  task automatic test_reset();
    start = 0; stop = 0; freq = 0; dur = 0;
    #2 nreset = 0;
    tick(); tick();
    checks++;
    if ({tone, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got tbd=%b exp=000", {tone, busy, done});
    end
    nreset = 1;
    tick(); tick();
    checks++;
    if ({tone, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release_idle got tbd=%b exp=000", {tone, busy, done});
    end
  endtask

  task automatic test_basic();
    int unsigned len;
    freq = 10'd1000; dur = 10'd3; start = 1;
    tick();
    start = 0;
    len = 3 * MS_CYCLES;
    for (int unsigned i = 0; i < len; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || tone !== exp_tone(i, 1000)) begin
        failures++;
        $display("FAIL basic_play cyc=%0d got tbd=%b%b%b exp=%b10", i, tone, busy, done,
                 exp_tone(i, 1000));
      end
      tick();
    end
    checks++;
    if ({tone, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL basic_done got tbd=%b exp=001", {tone, busy, done});
    end
    tick();
    checks++;
    if ({tone, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL basic_after got tbd=%b exp=000", {tone, busy, done});
    end
  endtask

  task automatic test_odd_freq();
    int unsigned len;
    int          edges;
    logic        prev;
    freq = 10'd3; dur = 10'd1000; start = 1;
    tick();
    start = 0;
    len = 1000 * MS_CYCLES;
    edges = 0;
    prev = 1'b0;
    for (int unsigned i = 0; i < len; i++) begin
      if (tone !== prev) edges++;
      prev = tone;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || tone !== exp_tone(i, 3)) begin
        failures++;
        $display("FAIL odd_play cyc=%0d got tbd=%b%b%b exp=%b10", i, tone, busy, done,
                 exp_tone(i, 3));
      end
      tick();
    end
    if (tone !== prev) edges++;
    checks++;
    if ({tone, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL odd_done got tbd=%b exp=001", {tone, busy, done});
    end
    checks++;
    if (edges != 6) begin
      failures++;
      $display("FAIL odd_edge_count got=%0d exp=6", edges);
    end
    tick();
  endtask

  task automatic test_silence_zero();
    freq = 10'd0; dur = 10'd2; start = 1;
    tick();
    start = 0;
    for (int unsigned i = 0; i < 2 * MS_CYCLES; i++) begin
      checks++;
      if ({tone, busy, done} !== 3'b010) begin
        failures++;
        $display("FAIL silence_play cyc=%0d got tbd=%b exp=010", i, {tone, busy, done});
      end
      tick();
    end
    checks++;
    if ({tone, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL silence_done got tbd=%b exp=001", {tone, busy, done});
    end
    tick();
    freq = 10'd500; dur = 10'd0; start = 1;
    tick();
    start = 0;
    checks++;
    if ({tone, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL zero_dur_done got tbd=%b exp=001", {tone, busy, done});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({tone, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL zero_dur_idle cyc=%0d got tbd=%b exp=000", i, {tone, busy, done});
      end
    end
  endtask

  task automatic test_abort();
    freq = 10'd1000; dur = 10'd5; start = 1;
    tick();
    start = 0;
    for (int unsigned i = 0; i <= 25; i++) begin
      if (i == 16) start = 0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || tone !== exp_tone(i, 1000)) begin
        failures++;
        $display("FAIL abort_play cyc=%0d got tbd=%b%b%b exp=%b10", i, tone, busy, done,
                 exp_tone(i, 1000));
      end
      if (i == 15) begin
        start = 1; freq = 10'd200; dur = 10'd1;
      end
      if (i == 25) stop = 1;
      if (i != 25) tick();
    end
    tick();
    stop = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({tone, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL abort_after cyc=%0d got tbd=%b exp=000", i, {tone, busy, done});
      end
      tick();
    end
    freq = 10'd1000; dur = 10'd2; start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tone, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL stop_wins cyc=%0d got tbd=%b exp=000", i, {tone, busy, done});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    freq = 10'd1000; dur = 10'd5; start = 1;
    tick();
    start = 0;
    for (int unsigned i = 0; i < 33; i++) tick();
    checks++;
    if ({tone, busy, done} !== {exp_tone(33, 1000), 2'b10}) begin
      failures++;
      $display("FAIL mid_note_state got tbd=%b exp=%b10", {tone, busy, done}, exp_tone(33, 1000));
    end
    nreset = 0;
    #1;
    checks++;
    if ({tone, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got tbd=%b exp=000", {tone, busy, done});
    end
    tick();
    nreset = 1;
    tick();
    checks++;
    if ({tone, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_no_resume got tbd=%b exp=000", {tone, busy, done});
    end
    freq = 10'd1000; dur = 10'd1; start = 1;
    tick();
    start = 0;
    for (int unsigned i = 0; i < MS_CYCLES; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || tone !== exp_tone(i, 1000)) begin
        failures++;
        $display("FAIL b2b_first cyc=%0d got tbd=%b%b%b exp=%b10", i, tone, busy, done,
                 exp_tone(i, 1000));
      end
      tick();
    end
    checks++;
    if ({tone, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_first_done got tbd=%b exp=001", {tone, busy, done});
    end
    freq = 10'd1000; dur = 10'd2; start = 1;
    tick();
    start = 0;
    for (int unsigned i = 0; i < 2 * MS_CYCLES; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || tone !== exp_tone(i, 1000)) begin
        failures++;
        $display("FAIL b2b_second cyc=%0d got tbd=%b%b%b exp=%b10", i, tone, busy, done,
                 exp_tone(i, 1000));
      end
      tick();
    end
    checks++;
    if ({tone, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_second_done got tbd=%b exp=001", {tone, busy, done});
    end
    tick();
  endtask

  task automatic test_random();
    int unsigned f;
    int unsigned d;
    freq = 10'($urandom_range(0, 1023));
    dur  = 10'($urandom_range(0, 4));
    start = 1;
    for (int n = 0; n < 10; n++) begin
      f = freq;
      d = dur;
      tick();
      start = 0;
      for (int unsigned i = 0; i < d * MS_CYCLES; i++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || tone !== exp_tone(i, f)) begin
          failures++;
          $display("FAIL rand_play n=%0d f=%0d cyc=%0d got tbd=%b%b%b exp=%b10", n, f, i,
                   tone, busy, done, exp_tone(i, f));
        end
        if (i == 3) begin
          freq = 10'($urandom_range(0, 1023));
          dur  = 10'($urandom_range(1, 9));
        end
        tick();
      end
      checks++;
      if ({tone, busy, done} !== 3'b001) begin
        failures++;
        $display("FAIL rand_done n=%0d f=%0d d=%0d got tbd=%b exp=001", n, f, d,
                 {tone, busy, done});
      end
      freq = 10'($urandom_range(0, 1023));
      dur  = 10'($urandom_range(0, 4));
      start = (n < 9);
    end
    start = 0;
    tick();
    checks++;
    if ({tone, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL rand_final got tbd=%b exp=000", {tone, busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_freq();
    test_silence_zero();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
